// File: rtl/board_io_pkg.sv
// Shared board-I/O types: blink FSM state encoding and timer sizing helper.
package board_io_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ON   = 2'b01,
        GAP  = 2'b10
    } state_e;

    // Bits needed to hold the larger of the two phase lengths.
    function automatic int timer_width(input int on_cycles, input int gap_cycles);
        int m;
        m = (on_cycles > gap_cycles) ? on_cycles : gap_cycles;
        return (m + 1 > 2) ? $clog2(m + 1) : 1;
    endfunction

endpackage

// File: rtl/led_pulse_stretch_if.sv
// Event-in / LED-out bundle for the pulse stretcher.
interface led_pulse_stretch_if #(
    parameter int PEND_W = 3
);
    logic              we;
    logic              clr_ovf;
    logic              led;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              ovf;

    modport master (output we, clr_ovf, input led, busy, pending, ovf);
    modport slave  (input we, clr_ovf, output led, busy, pending, ovf);
endinterface

// File: rtl/led_pulse_stretch.sv
// Stretches single-cycle strobes into fixed-length LED blinks separated by a
// dark gap; strobes arriving mid-blink are queued in a saturating counter.
module led_pulse_stretch
    import board_io_pkg::*;
#(
    parameter int ON_CYCLES  = 10_000_000,
    parameter int GAP_CYCLES = 5_000_000,
    parameter int PEND_W     = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    led_pulse_stretch_if.slave  io
);

    localparam int TW = timer_width(ON_CYCLES, GAP_CYCLES);
    localparam logic [TW-1:0]     ON_LD    = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0]     GAP_LD   = TW'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_e            state;
    logic [TW-1:0]     timer;
    logic              led_q;
    logic [PEND_W-1:0] pend;
    logic              ovf_q;

    logic gap_end, start_we, inc, dec, ovf_set;

    // A strobe that can start a blink itself is never queued.
    always_comb begin
        gap_end  = (state == GAP) && (timer == '0);
        start_we = io.we && ((state == IDLE) || (gap_end && pend == '0));
        inc      = io.we && (state != IDLE) && !start_we;
        dec      = gap_end && (pend != '0);
        ovf_set  = inc && !dec && (pend == PEND_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            timer <= '0;
            led_q <= 1'b0;
            pend  <= '0;
            ovf_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (io.we) begin
                        state <= ON;
                        timer <= ON_LD;
                        led_q <= 1'b1;
                    end
                end
                ON: begin
                    if (timer == '0) begin
                        state <= GAP;
                        timer <= GAP_LD;
                        led_q <= 1'b0;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                GAP: begin
                    if (timer == '0) begin
                        if (io.we || pend != '0) begin
                            state <= ON;
                            timer <= ON_LD;
                            led_q <= 1'b1;
                        end else begin
                            state <= IDLE;
                            timer <= '0;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                    led_q <= 1'b0;
                end
            endcase

            if (inc && !dec && pend != PEND_MAX) pend <= pend + PEND_W'(1);
            else if (dec && !inc)                pend <= pend - PEND_W'(1);

            // Set has priority over a simultaneous clear.
            if (ovf_set)         ovf_q <= 1'b1;
            else if (io.clr_ovf) ovf_q <= 1'b0;
        end
    end

    assign io.led     = led_q;
    assign io.busy    = (state != IDLE);
    assign io.pending = pend;
    assign io.ovf     = ovf_q;

endmodule

// File: tb/tb_led_pulse_stretch.sv
// Directed bench for led_pulse_stretch with an elapsed-time blink model.
module tb_led_pulse_stretch;

    localparam int ON     = 4;
    localparam int GAP    = 2;
    localparam int PEND_W = 2;
    localparam int QMAX   = (1 << PEND_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    led_pulse_stretch_if #(.PEND_W(PEND_W)) bus ();

    led_pulse_stretch #(
        .ON_CYCLES (ON),
        .GAP_CYCLES(GAP),
        .PEND_W    (PEND_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .io   (bus.slave)
    );

    always #5 clk = ~clk;

    // Model: t = cycles since the current blink began (-1 when idle),
    // q = queued events. Outputs follow from t alone.
    int t     = -1;
    int q     = 0;
    bit m_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t     = -1;
            q     = 0;
            m_ovf = 1'b0;
        end else begin
            bit set;
            set = 1'b0;
            if (t < 0) begin
                if (bus.we) t = 0;
            end else if (t == ON + GAP - 1) begin
                if (q > 0) begin
                    t = 0;
                    q = q - 1;
                    if (bus.we) q = q + 1;
                end else if (bus.we) begin
                    t = 0;
                end else begin
                    t = -1;
                end
            end else begin
                t = t + 1;
                if (bus.we) begin
                    if (q == QMAX) set = 1'b1;
                    else           q = q + 1;
                end
            end
            if (set)               m_ovf = 1'b1;
            else if (bus.clr_ovf)  m_ovf = 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("cyc_led",     int'(bus.led),     int'(t >= 0 && t < ON));
            chk("cyc_busy",    int'(bus.busy),    int'(t >= 0));
            chk("cyc_pending", int'(bus.pending), q);
            chk("cyc_ovf",     int'(bus.ovf),     int'(m_ovf));
        end
    end

    // Drive inputs for one edge; on return the edge's results are visible.
    task automatic step(input bit w, input bit c);
        bus.we      = w;
        bus.clr_ovf = c;
        @(posedge clk);
        #1;
        bus.we      = 1'b0;
        bus.clr_ovf = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    initial begin
        int rises;
        bit prev;
        rst_n       = 1'b0;
        bus.we      = 1'b0;
        bus.clr_ovf = 1'b0;
        #12;
        chk("rst_led",     int'(bus.led),     0);
        chk("rst_busy",    int'(bus.busy),    0);
        chk("rst_pending", int'(bus.pending), 0);
        chk("rst_ovf",     int'(bus.ovf),     0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single event: E0..E3 lit, dark from E4, idle after E6.
        step(1'b1, 1'b0);
        chk("s_led_e0", int'(bus.led), 1);
        for (int i = 1; i <= 6; i++) begin
            step(1'b0, 1'b0);
            if (i == 3) chk("s_led_e3",  int'(bus.led),  1);
            if (i == 4) chk("s_led_e4",  int'(bus.led),  0);
            if (i == 5) chk("s_busy_e5", int'(bus.busy), 1);
            if (i == 6) chk("s_busy_e6", int'(bus.busy), 0);
        end
        chk("s_pending", int'(bus.pending), 0);
        idle(2);

        // Three events back to back.
        for (int i = 0; i <= 18; i++) begin
            step(i <= 2, 1'b0);
            if (i == 1)  chk("t_pend_e1",  int'(bus.pending), 1);
            if (i == 2)  chk("t_pend_e2",  int'(bus.pending), 2);
            if (i == 5)  chk("t_led_e5",   int'(bus.led),     0);
            if (i == 6)  chk("t_led_e6",   int'(bus.led),     1);
            if (i == 6)  chk("t_pend_e6",  int'(bus.pending), 1);
            if (i == 12) chk("t_led_e12",  int'(bus.led),     1);
            if (i == 12) chk("t_pend_e12", int'(bus.pending), 0);
            if (i == 17) chk("t_busy_e17", int'(bus.busy),    1);
            if (i == 18) chk("t_busy_e18", int'(bus.busy),    0);
        end
        chk("t_ovf", int'(bus.ovf), 0);
        idle(2);

        // Five events: the fifth overflows; exactly four blinks.
        rises = 0;
        prev  = 1'b0;
        for (int i = 0; i <= 30; i++) begin
            step(i <= 4, 1'b0);
            if (bus.led && !prev) rises++;
            prev = bus.led;
            if (i == 3) chk("o_pend_e3", int'(bus.pending), 3);
            if (i == 4) chk("o_pend_e4", int'(bus.pending), 3);
            if (i == 4) chk("o_ovf_e4",  int'(bus.ovf),     1);
        end
        chk("o_blinks", rises, 4);
        chk("o_ovf_end", int'(bus.ovf), 1);
        chk("o_idle", int'(bus.busy), 0);

        // Clear colliding with a new overflow: set wins; clear alone works.
        for (int i = 0; i <= 3; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("c_ovf_set_wins", int'(bus.ovf), 1);
        step(1'b0, 1'b1);
        chk("c_ovf_cleared", int'(bus.ovf), 0);
        idle(30);

        // Event on the last GAP cycle while one is queued.
        for (int i = 0; i <= 12; i++) begin
            step(i <= 1 || i == 6, 1'b0);
            if (i == 5) chk("g_pend_e5", int'(bus.pending), 1);
            if (i == 6) chk("g_led_e6",  int'(bus.led),     1);
            if (i == 6) chk("g_pend_e6", int'(bus.pending), 1);
        end
        idle(20);
        chk("g_idle", int'(bus.busy), 0);

        // Reset mid-blink with pending and ovf non-zero.
        for (int i = 0; i <= 7; i++) step(i <= 4, 1'b0);
        chk("r_pre_led", int'(bus.led), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_led",     int'(bus.led),     0);
        chk("r_busy",    int'(bus.busy),    0);
        chk("r_pending", int'(bus.pending), 0);
        chk("r_ovf",     int'(bus.ovf),     0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0);
        rises = 1;
        for (int i = 1; i <= 6; i++) begin
            step(1'b0, 1'b0);
            if (bus.led) rises++;
        end
        chk("r_blink_len", rises, ON);
        chk("r_idle", int'(bus.busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
